// File: rtl/multisim_pkg.sv
// Shared types and the simulation channel used by multisim server/client blocks.
// Latency: n/a (types and channel functions only).
// Backpressure: a get on an empty channel returns 0 and leaves the word cleared.
package multisim_pkg;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        POLL       = 2'd1,
        BACKOFF    = 2'd2
    } ms_state_t;

    // Widest payload a channel word can carry; blocks slice down to their own width.
    localparam int MS_MAX_WIDTH = 256;

    // Channel state: words queued by the client side, pulled by the server side.
    logic [MS_MAX_WIDTH-1:0] ms_chan_q[$];
    int unsigned             ms_start_calls = 0;
    int unsigned             ms_get_calls   = 0;
    string                   ms_server_name = "";

    // Open the server end of the channel.
    function automatic void multisim_server_start(input string name);
        ms_start_calls++;
        ms_server_name = name;
    endfunction

    // Pull one word; returns 1 with the word (masked to width bits) or 0 when empty.
    function automatic int multisim_server_get_data_packed(
        input  string                   name,
        output logic [MS_MAX_WIDTH-1:0] word,
        input  int                      width
    );
        ms_get_calls++;
        ms_server_name = name;
        word = '0;
        if (ms_chan_q.size() == 0) begin
            return 0;
        end
        word = ms_chan_q.pop_front();
        for (int i = width; i < MS_MAX_WIDTH; i++) begin
            word[i] = 1'b0;
        end
        return 1;
    endfunction

    // Client side: queue a word for the server to pull.
    function automatic void multisim_client_send(input logic [MS_MAX_WIDTH-1:0] word);
        ms_chan_q.push_back(word);
    endfunction

endpackage

// File: rtl/multisim_fifo.sv
// Generic circular buffer for multisim server/client blocks.
// Latency: a word pushed at an edge is at rd_dat right after that edge.
// Backpressure: push while full and pop while empty are ignored; callers gate on full/empty.
module multisim_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multisim_server_pull.sv
// Server end of a multisim channel: polls the channel and presents words on a valid/ready port.
// Latency: a successful get is visible on data/data_vld one cycle later (after its push edge).
// Backpressure: no get while the buffer is full; outputs hold while data_vld && !data_rdy.
module multisim_server_pull
    import multisim_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int POLL_BACKOFF = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  string                 server_name,
    output logic                  data_vld,
    input  logic                  data_rdy,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int         CW      = $clog2(FIFO_DEPTH+1);
    localparam logic [7:0] BO_LOAD = (POLL_BACKOFF > 0) ? 8'(POLL_BACKOFF - 1) : 8'd0;

    ms_state_t             state;
    ms_state_t             state_nxt;
    logic [7:0]            bo_cnt;
    logic [7:0]            bo_nxt;
    logic                  start_done = 1'b0;
    logic                  get_issued;
    logic                  get_hit;
    logic [DATA_WIDTH-1:0] get_word;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  pop;

    // Open the channel once; polling is held off until this returns.
    initial begin
        multisim_server_start(server_name);
        start_done = 1'b1;
    end

    // One channel pull: {hit, word truncated to DATA_WIDTH}.
    function automatic logic [DATA_WIDTH:0] poll_channel();
        logic [MS_MAX_WIDTH-1:0] word;
        int                      hit;
        hit = multisim_server_get_data_packed(server_name, word, DATA_WIDTH);
        return {hit != 0, word[DATA_WIDTH-1:0]};
    endfunction

    // Pull mid-cycle, deciding on the full flag as it stood at the start of the
    // cycle, so the result is a settled push input at the following edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            get_issued <= 1'b0;
            get_hit    <= 1'b0;
            get_word   <= '0;
        end else if (state == POLL && !full) begin
            get_issued            <= 1'b1;
            {get_hit, get_word}   <= poll_channel();
        end else begin
            get_issued <= 1'b0;
            get_hit    <= 1'b0;
        end
    end

    // Poll sequencing: an empty poll parks in BACKOFF for POLL_BACKOFF cycles.
    always_comb begin
        state_nxt = state;
        bo_nxt    = bo_cnt;
        case (state)
            WAIT_START: begin
                if (start_done) state_nxt = POLL;
            end
            POLL: begin
                if (get_issued && !get_hit && (POLL_BACKOFF > 0)) begin
                    state_nxt = BACKOFF;
                    bo_nxt    = BO_LOAD;
                end
            end
            BACKOFF: begin
                if (bo_cnt == 8'd0) state_nxt = POLL;
                else                bo_nxt    = bo_cnt - 8'd1;
            end
            default: state_nxt = WAIT_START;
        endcase
    end

    // State register; leaving reset goes straight to POLL once the channel is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= start_done ? POLL : WAIT_START;
            bo_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            bo_cnt <= bo_nxt;
        end
    end

    assign pop      = data_rdy && !empty;
    assign data_vld = (count != '0);

    multisim_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (get_hit),
        .wr_dat (get_word),
        .pop    (pop),
        .rd_dat (data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

endmodule

// File: tb/tb_multisim_server_pull.sv
module tb_multisim_server_pull;
    import multisim_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int BO    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          data_rdy;
    logic          data_vld;
    logic [DW-1:0] data;
    string         server_name = "chan0";

    always #5 clk = ~clk;

    multisim_server_pull #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .POLL_BACKOFF (BO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .server_name (server_name),
        .data_vld    (data_vld),
        .data_rdy    (data_rdy),
        .data        (data)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: buffered words, words waiting in the channel, idle cycles
    // left before the next poll is allowed, and the number of gets expected.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] pend[$];
    int            idle     = 0;
    int            exp_gets = 0;
    bit            cur_rdy  = 1'b0;
    bit            cur_rst  = 1'b1;

    // Words actually handed over by the DUT, with the cycle they went out on.
    logic [DW-1:0] got[$];
    int            got_cyc[$];
    int            cyc = 0;
    logic [DW-1:0] wl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of the reference: pop decided on start-of-cycle contents, a
    // get only when not full at start of cycle and not idling; an empty get
    // makes the next BO cycles idle.
    function automatic void model_step();
        bit full0;
        if (cur_rst) begin
            mq.delete();
            idle = 0;
            return;
        end
        full0 = (mq.size() >= DEPTH);
        if (cur_rdy && mq.size() != 0) void'(mq.pop_front());
        if (idle > 0) begin
            idle--;
        end else if (!full0) begin
            exp_gets++;
            if (pend.size() != 0) mq.push_back(pend.pop_front());
            else                  idle = BO;
        end
    endfunction

    // Delivery monitor, mid-cycle when data/data_vld/data_rdy are settled.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && data_vld && data_rdy) begin
            got.push_back(data);
            got_cyc.push_back(cyc);
        end
    end

    // Advance one cycle, then compare the DUT against the model.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check("vld", data_vld, mq.size() != 0);
        if (mq.size() != 0) check("data", data, mq[0]);
        check("gets", ms_get_calls, exp_gets);
    endtask

    task automatic set_rdy(input bit b);
        data_rdy = b;
        cur_rdy  = b;
    endtask

    // Queue a word with garbage above DW so truncation is exercised.
    task automatic send(input logic [DW-1:0] v);
        logic [MS_MAX_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < MS_MAX_WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
        w[DW-1:0] = v;
        multisim_client_send(w);
        pend.push_back(v);
    endtask

    task automatic check_list(input string nm);
        check({nm, "_len"}, got.size(), wl.size());
        for (int i = 0; i < wl.size() && i < got.size(); i++) check({nm, "_word"}, got[i], wl[i]);
    endtask

    initial begin
        int g0;
        int d0;
        int sent;
        logic [DW-1:0] v;

        rst_n    = 1'b1;
        data_rdy = 1'b0;
        #1 rst_n = 1'b0;
        cur_rst  = 1'b1;
        #1;
        check("rst_vld", data_vld, 1'b0);
        check("rst_data", data, '0);
        check("start_calls", ms_start_calls, 1);
        repeat (3) tick();
        check("rst_no_gets", ms_get_calls, 0);
        rst_n   = 1'b1;
        cur_rst = 1'b0;

        // Three words, consumer always ready.
        set_rdy(1'b1);
        repeat (12) tick();
        got.delete(); got_cyc.delete();
        send(32'h1); send(32'h2); send(32'h3);
        repeat (15) tick();
        check("s1_len", got.size(), 3);
        if (got.size() == 3) begin
            check("s1_w0", got[0], 32'h1);
            check("s1_w1", got[1], 32'h2);
            check("s1_w2", got[2], 32'h3);
            check("s1_consec01", got_cyc[1] - got_cyc[0], 1);
            check("s1_consec12", got_cyc[2] - got_cyc[1], 1);
        end

        // Six words into a four-deep buffer with the consumer stalled.
        set_rdy(1'b0);
        got.delete(); wl.delete();
        for (int i = 0; i < 6; i++) begin v = $urandom; wl.push_back(v); send(v); end
        repeat (14) tick();
        check("s2_vld", data_vld, 1'b1);
        check("s2_chan_left", ms_chan_q.size(), 2);
        g0 = ms_get_calls;
        repeat (5) tick();
        check("s2_no_get_full", ms_get_calls - g0, 0);
        set_rdy(1'b1);
        repeat (12) tick();
        check_list("s2");

        // Full buffer, consumer alternating: one word and one get per two cycles.
        set_rdy(1'b0);
        got.delete(); wl.delete();
        for (int i = 0; i < 12; i++) begin v = $urandom; wl.push_back(v); send(v); end
        repeat (14) tick();
        g0 = ms_get_calls;
        d0 = got.size();
        for (int i = 0; i < 8; i++) begin set_rdy(i % 2 == 0); tick(); end
        check("s4_gets", ms_get_calls - g0, 4);
        check("s4_words", got.size() - d0, 4);
        set_rdy(1'b1);
        repeat (20) tick();
        check_list("s4");

        // Sixteen words with ready toggling every cycle.
        got.delete(); wl.delete();
        for (int i = 0; i < 16; i++) begin v = $urandom; wl.push_back(v); send(v); end
        for (int i = 0; i < 60; i++) begin set_rdy(i % 2 == 0); tick(); end
        check_list("s6");

        // Idle channel: one poll every BO+1 cycles, nothing valid.
        set_rdy(1'b1);
        repeat (20) tick();
        g0 = ms_get_calls;
        repeat (36) tick();
        check("s3_poll_rate", ms_get_calls - g0, 4);
        check("s3_vld", data_vld, 1'b0);

        // Reset with three words buffered.
        set_rdy(1'b0);
        for (int i = 0; i < 3; i++) send($urandom);
        repeat (14) tick();
        check("s5_vld_before", data_vld, 1'b1);
        rst_n   = 1'b0;
        cur_rst = 1'b1;
        #1;
        check("s5_vld_async", data_vld, 1'b0);
        check("s5_data_async", data, '0);
        g0 = ms_get_calls;
        wl.delete();
        for (int i = 0; i < 2; i++) begin v = $urandom; wl.push_back(v); send(v); end
        repeat (3) tick();
        check("s5_no_get_in_rst", ms_get_calls - g0, 0);
        rst_n   = 1'b1;
        cur_rst = 1'b0;
        got.delete();
        set_rdy(1'b1);
        repeat (8) tick();
        check_list("s5");
        check("s5_start_calls", ms_start_calls, 1);

        // Random traffic and random ready.
        got.delete(); wl.delete();
        sent = 0;
        for (int i = 0; i < 400; i++) begin
            set_rdy($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin v = $urandom; wl.push_back(v); send(v); sent++; end
            tick();
        end
        set_rdy(1'b1);
        repeat (60) tick();
        check_list("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
